// File: rtl/synth_pkg.sv
// ============================================================================
// Module  : synth_pkg
// Brief   : Shared constants, entry field positions and FSM encoding for the
//           note sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package synth_pkg;

  localparam int STEPS    = 16;
  localparam int NOTE_W   = 7;
  localparam int ENTRY_W  = 8;
  localparam int REST_BIT = 7;
  localparam int STEP_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_GATE_ON   = 2'd2,
    ST_GATE_OFF  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tick_edge_sync.sv
// ============================================================================
// Module  : tick_edge_sync
// Brief   : Two-flop synchronizer plus history flop for the step tick, with
//           registered rise/fall strobes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tick_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;
  logic r_rise;
  logic r_fall;
  logic w_rise;
  logic w_fall;

  assign w_rise = r_sync & ~r_hist;
  assign w_fall = ~r_sync & r_hist;

  // Strobes are registered so the FSM sees a clean single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_tick;
      r_sync <= r_meta;
      r_hist <= r_sync;
      r_rise <= w_rise;
      r_fall <= w_fall;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// ============================================================================
// Module  : note_sequencer
// Brief   : Step sequencer playing a 16-entry note/rest pattern on tick edges.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module note_sequencer
  import synth_pkg::*;
#(
  parameter int STEPS  = synth_pkg::STEPS,
  parameter int NOTE_W = synth_pkg::NOTE_W
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              tick_in,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [3:0]        len,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              gate,
  output logic              note_valid,
  output logic [3:0]        step,
  output logic              busy
);

  localparam logic [STEP_W-1:0] C_LAST_MAX = STEP_W'(STEPS - 1);

  logic                w_rise;
  logic                w_fall;

  logic [ENTRY_W-1:0]  r_mem [STEPS];
  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  logic [STEP_W-1:0]   r_last;
  logic [NOTE_W-1:0]   r_note;
  logic                r_gate;
  logic                r_valid;

  state_t              w_state_nxt;
  logic [STEP_W-1:0]   w_step_nxt;
  logic [STEP_W-1:0]   w_last_nxt;
  logic [NOTE_W-1:0]   w_note_nxt;
  logic                w_gate_nxt;
  logic                w_valid_nxt;
  logic [STEP_W-1:0]   w_rd_idx;
  logic [ENTRY_W-1:0]  w_entry;
  logic                w_load;

  tick_edge_sync u_tick_sync (
    .clk    (CLOCK_50),
    .rst    (reset),
    .i_tick (tick_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Pattern store: non-blocking write means a same-cycle read sees old data.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_last  <= '0;
      r_note  <= '0;
      r_gate  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_last  <= w_last_nxt;
      r_note  <= w_note_nxt;
      r_gate  <= w_gate_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_last_nxt  = r_last;
    w_note_nxt  = r_note;
    w_gate_nxt  = r_gate;
    w_valid_nxt = 1'b0;
    w_rd_idx    = r_step;
    w_load      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_step_nxt  = '0;
          w_last_nxt  = (len == 4'd0) ? C_LAST_MAX : (len - 4'd1);
          w_state_nxt = ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        if (w_rise) begin
          w_load = 1'b1;
        end
      end
      ST_GATE_ON: begin
        if (w_fall) begin
          w_gate_nxt  = 1'b0;
          w_state_nxt = ST_GATE_OFF;
        end
      end
      ST_GATE_OFF: begin
        if (w_rise) begin
          if (r_step != r_last) begin
            w_step_nxt = r_step + 4'd1;
            w_rd_idx   = r_step + 4'd1;
            w_load     = 1'b1;
          end else if (loop_en) begin
            w_step_nxt = '0;
            w_rd_idx   = '0;
            w_load     = 1'b1;
          end else begin
            w_gate_nxt  = 1'b0;
            w_step_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_entry = r_mem[w_rd_idx];
    if (w_load) begin
      w_note_nxt  = w_entry[NOTE_W-1:0];
      w_gate_nxt  = ~w_entry[REST_BIT];
      w_valid_nxt = 1'b1;
      w_state_nxt = ST_GATE_ON;
    end

    // Stop overrides everything, including a same-cycle start.
    if (stop) begin
      w_state_nxt = ST_IDLE;
      w_gate_nxt  = 1'b0;
      w_step_nxt  = '0;
      w_valid_nxt = 1'b0;
    end
  end

  assign note_out   = r_note;
  assign gate       = r_gate;
  assign note_valid = r_valid;
  assign step       = r_step;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// ============================================================================
// Module  : tb_note_sequencer
// Brief   : Directed self-checking bench for note_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_note_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       tick_in  = 1'b0;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic       loop_en  = 1'b0;
  logic [3:0] len      = 4'd4;
  logic       wr_en    = 1'b0;
  logic [3:0] wr_addr  = 4'd0;
  logic [7:0] wr_data  = 8'd0;
  logic [6:0] note_out;
  logic       gate;
  logic       note_valid;
  logic [3:0] step;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] cap_note;
  logic       cap_gate;
  logic [3:0] cap_step;
  logic       cap_seen;

  // Step 2 is a rest entry carrying code 64 (0xC0 = rest bit + 0x40).
  logic [6:0] pn [4] = '{7'h3C, 7'h3E, 7'h40, 7'h43};

  note_sequencer #(.STEPS(16), .NOTE_W(7)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tick_in    (tick_in),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .len        (len),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .note_out   (note_out),
    .gate       (gate),
    .note_valid (note_valid),
    .step       (step),
    .busy       (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLOCK_50);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge CLOCK_50);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLOCK_50); start = 1'b1;
    @(negedge CLOCK_50); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge CLOCK_50); stop = 1'b1;
    @(negedge CLOCK_50); stop = 1'b0;
  endtask

  task automatic tick_rise();
    cap_seen = 1'b0;
    @(negedge CLOCK_50); tick_in = 1'b1;
    for (int i = 0; i < 8 && !cap_seen; i++) begin
      @(negedge CLOCK_50);
      if (note_valid) begin
        cap_seen = 1'b1;
        cap_note = note_out;
        cap_gate = gate;
        cap_step = step;
      end
    end
  endtask

  task automatic tick_fall();
    @(negedge CLOCK_50); tick_in = 1'b0;
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic play(input string tag, input logic [3:0] est,
                      input logic [6:0] enote, input logic egate);
    tick_rise();
    chk({tag, "/valid_seen"}, 32'(cap_seen), 32'd1);
    chk({tag, "/step"},       32'(cap_step), 32'(est));
    chk({tag, "/note"},       32'(cap_note), 32'(enote));
    chk({tag, "/gate"},       32'(cap_gate), 32'(egate));
    tick_fall();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLOCK_50);
    chk("rst/gate",  32'(gate), 32'd0);
    chk("rst/busy",  32'(busy), 32'd0);
    chk("rst/step",  32'(step), 32'd0);
    chk("rst/note",  32'(note_out), 32'd0);
    chk("rst/valid", 32'(note_valid), 32'd0);
    @(negedge CLOCK_50); reset = 1'b0;

    wr(4'd0, 8'h3C);
    wr(4'd1, 8'h3E);
    wr(4'd2, 8'hC0);
    wr(4'd3, 8'h43);

    // One-shot, len changed mid-run must be ignored
    len = 4'd4; loop_en = 1'b0;
    pulse_start();
    chk("os/busy", 32'(busy), 32'd1);
    len = 4'd2;
    for (int i = 0; i < 4; i++) begin
      play("oneshot", 4'(i), pn[i], 1'(i != 2));
    end
    @(negedge CLOCK_50); tick_in = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    chk("os_end/busy", 32'(busy), 32'd0);
    chk("os_end/step", 32'(step), 32'd0);
    chk("os_end/gate", 32'(gate), 32'd0);
    chk("os_end/note", 32'(note_out), 32'h43);
    tick_fall();
    len = 4'd4;

    // Looping, with an ignored start while busy
    loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      play("loop", 4'(i % 4), pn[i % 4], 1'((i % 4) != 2));
      if (i == 1) pulse_start();
    end
    pulse_stop();
    chk("loop_stop/busy", 32'(busy), 32'd0);
    chk("loop_stop/note", 32'(note_out), 32'h3E);

    // Latency: tick rises 1 ns before edge k
    pulse_start();
    @(negedge CLOCK_50); #9 tick_in = 1'b1;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50); #1 chk("lat/k+1", 32'(note_valid), 32'd0);
    @(posedge CLOCK_50); #1 chk("lat/k+2", 32'(note_valid), 32'd0);
    @(posedge CLOCK_50); #1 chk("lat/k+3", 32'(note_valid), 32'd1);
    chk("lat/gate", 32'(gate), 32'd1);
    @(posedge CLOCK_50); #1 chk("lat/k+4", 32'(note_valid), 32'd0);
    repeat (2) @(negedge CLOCK_50);
    #9 tick_in = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50); #1 chk("fall/k+1", 32'(gate), 32'd1);
    @(posedge CLOCK_50); #1 chk("fall/k+2", 32'(gate), 32'd1);
    @(posedge CLOCK_50); #1 chk("fall/k+3", 32'(gate), 32'd0);
    pulse_stop();

    // Start and stop together: stop wins
    @(negedge CLOCK_50); start = 1'b1; stop = 1'b1;
    @(negedge CLOCK_50); start = 1'b0; stop = 1'b0;
    chk("ss/busy", 32'(busy), 32'd0);
    tick_rise();
    chk("ss/no_valid", 32'(cap_seen), 32'd0);
    chk("ss/busy2", 32'(busy), 32'd0);
    tick_fall();

    // Stop during GATE_ON at step 1
    pulse_start();
    play("gs", 4'd0, 7'h3C, 1'b1);
    tick_rise();
    chk("gs/step1", 32'(cap_step), 32'd1);
    chk("gs/gate1", 32'(cap_gate), 32'd1);
    pulse_stop();
    chk("gs_stop/gate", 32'(gate), 32'd0);
    chk("gs_stop/step", 32'(step), 32'd0);
    chk("gs_stop/busy", 32'(busy), 32'd0);
    chk("gs_stop/note", 32'(note_out), 32'h3E);
    tick_fall();

    // Write the playing address during GATE_ON
    pulse_start();
    tick_rise();
    chk("wr/step0", 32'(cap_step), 32'd0);
    wr(4'd0, 8'h48);
    chk("wr/note_hold", 32'(note_out), 32'h3C);
    chk("wr/gate_hold", 32'(gate), 32'd1);
    tick_fall();
    for (int i = 1; i < 4; i++) begin
      play("wr_pass", 4'(i), pn[i], 1'(i != 2));
    end
    play("wr_new", 4'd0, 7'h48, 1'b1);
    pulse_stop();

    // Asynchronous reset mid-GATE_ON
    pulse_start();
    play("ar", 4'd0, 7'h48, 1'b1);
    tick_rise();
    chk("ar/gate_on", 32'(gate), 32'd1);
    @(negedge CLOCK_50); #3 reset = 1'b1;
    #1;
    chk("ar/gate", 32'(gate), 32'd0);
    chk("ar/busy", 32'(busy), 32'd0);
    chk("ar/step", 32'(step), 32'd0);
    chk("ar/note", 32'(note_out), 32'd0);
    tick_in = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    tick_rise();
    chk("ar/idle_novalid", 32'(cap_seen), 32'd0);
    chk("ar/idle_busy",    32'(busy), 32'd0);
    tick_fall();
    len = 4'd0; loop_en = 1'b0;
    pulse_start();
    play("ar_clr0", 4'd0, 7'h00, 1'b1);
    play("ar_clr1", 4'd1, 7'h00, 1'b1);
    play("ar_clr2", 4'd2, 7'h00, 1'b1);
    pulse_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
